// File: rtl/alu_cmd_sequencer_if.sv
// Command/ALU/response signal bundle for alu_cmd_sequencer.
// slave: sequencer view; master: environment (command source, ALU, response sink).
interface alu_cmd_sequencer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [3:0]      cmd_a;
  logic [3:0]      cmd_b;
  logic [1:0]      cmd_op;
  logic [3:0]      alu_a;
  logic [3:0]      alu_b;
  logic [1:0]      alu_opcode;
  logic            alu_start;
  logic [7:0]      alu_result;
  logic            alu_done;
  logic            alu_error;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [7:0]      rsp_result;
  logic            rsp_error;
  logic            rsp_timeout;
  logic [CntW-1:0] fifo_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_done, alu_error, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_opcode, alu_start, rsp_valid, rsp_result, rsp_error,
           rsp_timeout, fifo_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_done, alu_error, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_opcode, alu_start, rsp_valid, rsp_result, rsp_error,
           rsp_timeout, fifo_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + single-outstanding issue FSM in front of the 4-bit ALU.
// Define ALU_CMD_STATS_EN to add saturating issue/error/timeout counters.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                clk,
  input logic                reset,
  alu_cmd_sequencer_if.slave bus
`ifdef ALU_CMD_STATS_EN
  ,
  output logic [15:0]        stat_issued,
  output logic [7:0]         stat_errors,
  output logic [7:0]         stat_timeouts
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  // Each entry packs {a, b, op}.
  logic [9:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [1:0]      state_q, state_d;
  logic [7:0]      timer_q, timer_d;

  logic [3:0]      alu_a_q, alu_a_d;
  logic [3:0]      alu_b_q, alu_b_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic            alu_start_q, alu_start_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_result_q, rsp_result_d;
  logic            rsp_error_q, rsp_error_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  logic            cmd_ready;
  logic            push;
  logic            pop;
  logic            timeout_hit;

  assign cmd_ready = (count_q != CntW'(DEPTH));
  assign push      = bus.cmd_valid && cmd_ready;

  // Timer holds WAIT cycles already completed, so WAIT lasts at most TIMEOUT cycles.
  assign timeout_hit = ((timer_q + 8'd1) == 8'(TIMEOUT));

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    alu_start_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    pop           = 1'b0;

    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        {alu_a_d, alu_b_d, alu_op_d} = mem_q[rd_ptr_q];
        alu_start_d = 1'b1;
        pop         = 1'b1;
        timer_d     = 8'd0;
        state_d     = StWait;
      end
      StWait: begin
        if (bus.alu_done) begin
          rsp_valid_d   = 1'b1;
          rsp_result_d  = bus.alu_result;
          rsp_error_d   = bus.alu_error;
          rsp_timeout_d = 1'b0;
          state_d       = StResp;
        end else if (timeout_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_result_d  = 8'd0;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b1;
          state_d       = StResp;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      timer_q       <= 8'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      alu_a_q       <= 4'd0;
      alu_b_q       <= 4'd0;
      alu_op_q      <= 2'd0;
      alu_start_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 8'd0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      alu_start_q   <= alu_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.fifo_count  = count_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_op_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_timeout = rsp_timeout_q;

`ifdef ALU_CMD_STATS_EN
  logic [15:0] issued_q;
  logic [7:0]  errors_q;
  logic [7:0]  timeouts_q;
  logic        err_evt;
  logic        to_evt;

  assign err_evt = (state_q == StWait) && bus.alu_done && bus.alu_error;
  assign to_evt  = (state_q == StWait) && !bus.alu_done && timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q   <= 16'd0;
      errors_q   <= 8'd0;
      timeouts_q <= 8'd0;
    end else begin
      if ((state_q == StIssue) && (issued_q != 16'hffff)) begin
        issued_q <= issued_q + 16'd1;
      end
      if (err_evt && (errors_q != 8'hff)) begin
        errors_q <= errors_q + 8'd1;
      end
      if (to_evt && (timeouts_q != 8'hff)) begin
        timeouts_q <= timeouts_q + 8'd1;
      end
    end
  end

  assign stat_issued   = issued_q;
  assign stat_errors   = errors_q;
  assign stat_timeouts = timeouts_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a small behavioural ALU.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.DEPTH(4)) bus ();

`ifdef ALU_CMD_STATS_EN
  logic [15:0] stat_issued;
  logic [7:0]  stat_errors;
  logic [7:0]  stat_timeouts;
`endif

  alu_cmd_sequencer #(
    .DEPTH   (4),
    .TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALU_CMD_STATS_EN
    ,
    .stat_issued   (stat_issued),
    .stat_errors   (stat_errors),
    .stat_timeouts (stat_timeouts)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // ALU model: Done one cycle after the start pulse unless hung or disabled.
  int   start_cnt = 0;
  int   dbl_start = 0;
  bit   model_en  = 1'b1;
  bit   hang      = 1'b0;
  bit   pend      = 1'b0;
  bit   prev_st   = 1'b0;
  logic [3:0] ma, mb;
  logic [1:0] mop;

  initial begin
    bus.alu_done   = 1'b0;
    bus.alu_result = 8'd0;
    bus.alu_error  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (model_en) begin
        bus.alu_done   = 1'b0;
        bus.alu_result = 8'd0;
        bus.alu_error  = 1'b0;
        if (pend) begin
          bus.alu_done = 1'b1;
          case (mop)
            2'd0: bus.alu_result = 8'(ma) + 8'(mb);
            2'd1: bus.alu_result = 8'(ma) - 8'(mb);
            2'd2: bus.alu_result = 8'(ma) * 8'(mb);
            default: begin
              if (mb == 4'd0) bus.alu_error = 1'b1;
              else bus.alu_result = 8'(ma / mb);
            end
          endcase
          pend = 1'b0;
        end
        if (bus.alu_start) begin
          start_cnt++;
          if (prev_st) dbl_start++;
          if (!hang) begin
            pend = 1'b1;
            ma   = bus.alu_a;
            mb   = bus.alu_b;
            mop  = bus.alu_opcode;
          end
        end
        prev_st = bus.alu_start;
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_a      = 4'd0;
    bus.cmd_b      = 4'd0;
    bus.cmd_op     = 2'd0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_start} !== 11'd0) begin
      failures++;
      $display("FAIL reset_alu: alu_*=%h required 0",
               {bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_start});
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.rsp_timeout} !== 11'd0) begin
      failures++;
      $display("FAIL reset_rsp: rsp_*=%h required 0",
               {bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.rsp_timeout});
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_fifo: cmd_ready=%b fifo_count=%0d required 1/0",
               bus.cmd_ready, bus.fifo_count);
    end
  endtask

  task automatic test_single;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 4'd5;
    bus.cmd_b     = 4'd3;
    bus.cmd_op    = 2'd0;
    @(negedge clk);  // edge N accepts
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.alu_start !== 1'b0 || bus.fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL t1_n0: alu_start=%b fifo_count=%0d required 0/1",
               bus.alu_start, bus.fifo_count);
    end
    @(negedge clk);  // N+1
    checks++;
    if (bus.alu_start !== 1'b0) begin
      failures++;
      $display("FAIL t1_n1_start: alu_start=%b required 0", bus.alu_start);
    end
    @(negedge clk);  // N+2
    checks++;
    if (bus.alu_start !== 1'b1) begin
      failures++;
      $display("FAIL t1_n2_start: alu_start=%b required 1", bus.alu_start);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_opcode} !== {4'd5, 4'd3, 2'd0}) begin
      failures++;
      $display("FAIL t1_operands: a=%0d b=%0d op=%0d required 5/3/0",
               bus.alu_a, bus.alu_b, bus.alu_opcode);
    end
    @(negedge clk);  // N+3
    checks++;
    if (bus.alu_start !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL t1_n3: alu_start=%b rsp_valid=%b required 0/0",
               bus.alu_start, bus.rsp_valid);
    end
    @(negedge clk);  // N+4
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.rsp_timeout} !==
        {1'b1, 8'd8, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL t1_rsp: valid=%b result=%0d err=%b to=%b required 1/8/0/0",
               bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.rsp_timeout);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL t1_handshake: rsp_valid=%b required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [4];
    int start0;
    int idx;
    bit ok;
    exp[0] = 8'd15; exp[1] = 8'd5; exp[2] = 8'd2; exp[3] = 8'd14;
    start0 = start_cnt;
    push(4'd10, 4'd4, 2'd1);
    push(4'd5,  4'd3, 2'd2);
    push(4'd10, 4'd2, 2'd3);
    push(4'd1,  4'd1, 2'd0);
    push(4'd7,  4'd7, 2'd0);
    wait_rsp(ok);
    checks++;
    if (!ok || bus.rsp_result !== 8'd6) begin
      failures++;
      $display("FAIL t2_first: valid=%b result=%0d required 1/6", ok, bus.rsp_result);
    end
    checks++;
    if (bus.fifo_count !== 3'd4 || bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL t2_full: fifo_count=%0d cmd_ready=%b required 4/0",
               bus.fifo_count, bus.cmd_ready);
    end
    push(4'd15, 4'd15, 2'd0);  // refused while full
    checks++;
    if (bus.fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL t2_no_bypass: fifo_count=%0d required 4", bus.fifo_count);
    end
    bus.rsp_ready = 1'b1;
    idx = 0;
    for (int i = 0; i < 200 && idx < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        checks++;
        if (bus.rsp_result !== exp[idx] || bus.rsp_error !== 1'b0) begin
          failures++;
          $display("FAIL t2_order%0d: result=%0d err=%b required %0d/0",
                   idx, bus.rsp_result, bus.rsp_error, exp[idx]);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 4) begin
      failures++;
      $display("FAIL t2_drain: responses=%0d required 4", idx);
    end
    repeat (6) @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if ((start_cnt - start0) != 5 || bus.rsp_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL t2_starts: starts=%0d rsp_valid=%b fifo_count=%0d required 5/0/0",
               start_cnt - start0, bus.rsp_valid, bus.fifo_count);
    end
  endtask

  task automatic test_error;
    bit ok;
    push(4'd8, 4'd0, 2'd3);
    wait_rsp(ok);
    checks++;
    if (!ok || {bus.rsp_result, bus.rsp_error, bus.rsp_timeout} !== {8'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL t3_div0: valid=%b result=%0d err=%b to=%b required 1/0/1/0",
               ok, bus.rsp_result, bus.rsp_error, bus.rsp_timeout);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    bit ok;
    bit seen;
    hang = 1'b1;
    push(4'd2, 4'd2, 2'd0);
    push(4'd3, 4'd4, 2'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.alu_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL t4_start: alu_start=0 required 1 within 20 cycles");
    end
    repeat (14) @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL t4_early: rsp_valid=%b required 0 after 14 WAIT cycles", bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.rsp_timeout} !==
        {1'b1, 8'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL t4_timeout: valid=%b result=%0d err=%b to=%b required 1/0/0/1",
               bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.rsp_timeout);
    end
    hang = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok || bus.rsp_result !== 8'd7 || bus.rsp_timeout !== 1'b0) begin
      failures++;
      $display("FAIL t4_next: valid=%b result=%0d to=%b required 1/7/0",
               ok, bus.rsp_result, bus.rsp_timeout);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_hold_resp;
    logic [7:0] exp [3];
    int idx;
    bit ok;
    exp[0] = 8'd8; exp[1] = 8'd9; exp[2] = 8'd14;
    push(4'd9, 4'd2, 2'd1);
    wait_rsp(ok);
    push(4'd4, 4'd4, 2'd0);
    push(4'd3, 4'd3, 2'd2);
    checks++;
    if (!ok || bus.fifo_count !== 3'd2) begin
      failures++;
      $display("FAIL t5_queue: valid=%b fifo_count=%0d required 1/2", ok, bus.fifo_count);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.rsp_timeout, bus.alu_start} !==
          {1'b1, 8'd7, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL t5_hold%0d: valid=%b result=%0d err=%b to=%b start=%b required 1/7/0/0/0",
                 i, bus.rsp_valid, bus.rsp_result, bus.rsp_error, bus.rsp_timeout,
                 bus.alu_start);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);  // handshake, back to IDLE
    bus.rsp_ready = 1'b0;
    @(negedge clk);  // now in ISSUE
    push(4'd15, 4'd1, 2'd1);  // push lands on the pop edge
    checks++;
    if (bus.fifo_count !== 3'd2 || bus.alu_start !== 1'b1) begin
      failures++;
      $display("FAIL t5_push_pop: fifo_count=%0d alu_start=%b required 2/1",
               bus.fifo_count, bus.alu_start);
    end
    bus.rsp_ready = 1'b1;
    idx = 0;
    for (int i = 0; i < 200 && idx < 3; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        checks++;
        if (bus.rsp_result !== exp[idx]) begin
          failures++;
          $display("FAIL t5_order%0d: result=%0d required %0d", idx, bus.rsp_result, exp[idx]);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 3) begin
      failures++;
      $display("FAIL t5_drain: responses=%0d required 3", idx);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    hang = 1'b1;
    push(4'd1, 4'd1, 2'd0);
    push(4'd2, 4'd2, 2'd0);
    push(4'd3, 4'd3, 2'd0);
    @(negedge clk);
    checks++;
    if (bus.fifo_count !== 3'd2 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL t6_pre: fifo_count=%0d rsp_valid=%b required 2/0",
               bus.fifo_count, bus.rsp_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.fifo_count !== 3'd0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
        bus.alu_start !== 1'b0) begin
      failures++;
      $display("FAIL t6_reset: fifo_count=%0d cmd_ready=%b rsp_valid=%b start=%b required 0/1/0/0",
               bus.fifo_count, bus.cmd_ready, bus.rsp_valid, bus.alu_start);
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_opcode} !== 10'd0) begin
      failures++;
      $display("FAIL t6_alu_clr: alu_*=%h required 0", {bus.alu_a, bus.alu_b, bus.alu_opcode});
    end
    model_en       = 1'b0;
    bus.alu_done   = 1'b1;
    bus.alu_result = 8'h55;
    @(negedge clk);
    bus.alu_done   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.alu_start !== 1'b0) begin
        failures++;
        $display("FAIL t6_late_done%0d: rsp_valid=%b start=%b required 0/0",
                 i, bus.rsp_valid, bus.alu_start);
      end
    end
    hang     = 1'b0;
    pend     = 1'b0;
    model_en = 1'b1;
    push(4'd6, 4'd6, 2'd0);
    wait_rsp(ok);
    checks++;
    if (!ok || bus.rsp_result !== 8'd12 || bus.rsp_timeout !== 1'b0) begin
      failures++;
      $display("FAIL t6_after: valid=%b result=%0d to=%b required 1/12/0",
               ok, bus.rsp_result, bus.rsp_timeout);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_error();
    test_timeout();
    test_hold_resp();
    test_reset_mid();
    checks++;
    if (dbl_start != 0) begin
      failures++;
      $display("FAIL start_width: multi-cycle start pulses=%0d required 0", dbl_start);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
